noc_pkt_packetizer: RTL and testbench
=====================================

// Module: noc_pkt_packetizer
// PURPOSE
// - Transmit side of the parser NoC flit protocol. Converts a DATA_WIDTH Avalon-ST packet stream into NOC_WIDTH flits.
// - Each flit holds 4 quarters; each quarter's top 3 bits are {valid, sop, eop}.
// - Each packet starts with a header flit carrying VC, destination router and dest_mod, so the downstream per-module sorter can steer it.
// - Sits between a packet source (traffic gen / upstream module) and the NoC fabric port.
// PARAMETERS
// - DATA_WIDTH  512               payload beat width; must equal 4*128.
// - NOC_WIDTH   600               flit width; quarter Q = NOC_WIDTH/4 = 150.
// - NUM_VC      2                 VC count; VCW = $clog2(NUM_VC).
// - NOC_RADIX   16                routers; RW = $clog2(NOC_RADIX).
// - VC_ID       0                 VC stamped in every header.
// - NUM_SRC     4                 number of destination routers in the rotation.
// - DEST        '{12,13,14,15}    destination router list, used round-robin per packet.
// PORTS
// - clk           in   1             clock.
// - reset         in   1             asynchronous, active-low reset.
// - i_data_in     in   DATA_WIDTH    payload beat; byte 0 is at the MSB.
// - i_valid_in    in   1             beat valid.
// - i_sop_in      in   1             first beat of packet.
// - i_eop_in      in   1             last beat of packet.
// - i_empty_in    in   6             unused bytes in the eop beat (0..63); ignored if !eop.
// - i_dest_mod_in in   3             target module (mod_t); sampled on the sop beat.
// - i_tag_in      in   32            packet tag; sampled on the sop beat.
// - i_ready_out   out  1             beat accepted when i_valid_in && i_ready_out.
// - o_data_out    out  NOC_WIDTH     flit.
// - o_valid_out   out  1             flit valid.
// - o_ready_in    in   1             flit accepted when o_valid_out && o_ready_in.
// - o_proto_err   out  1             one-cycle pulse: beat without sop received while idle.
// BEHAVIOUR
// - Reset (reset==0, async):
//   - o_valid_out=0, o_data_out=0, o_proto_err=0.
//   - FSM=HDR, rr_idx=0.
//   - i_ready_out=0 while reset is asserted.
// - Output register:
//   - adv = !o_valid_out || o_ready_in.
//   - The register loads on adv; it holds o_data_out/o_valid_out stable while stalled.
// - FSM HDR:
//   - i_ready_out=0 if i_valid_in && i_sop_in.
//   - On that condition and adv: load the header flit, latch dest_mod/tag, go BODY. The sop beat is not consumed.
//   - Otherwise i_ready_out=1: non-sop beats are dropped and o_proto_err pulses.
// - Header flit:
//   - Bits [NW-1:NW-3]=3'b110.
//   - Next VCW bits = VC_ID.
//   - Next RW bits = DEST[rr_idx].
//   - Then 1'b0, then tag[31:0], then 7'b0.
//   - Then dest_mod[2:0] at [NW-1-3-VCW-RW-1-32-7 -: 3], i.e. [551:549] at defaults.
//   - All other bits 0; quarters 0..2 have valid=0.
//   - rr_idx increments on header load and wraps NUM_SRC-1 -> 0.
// - FSM BODY:
//   - i_ready_out = adv.
//   - On an accepted beat, load a data flit. Quarter k (3..0) bits [Q*k+127:Q*k] = i_data_in[128*k+127:128*k]. Bits [Q*k+146:Q*k+128]=0. sop bits=0.
//   - Non-eop beat: all 4 valid bits = 1.
//   - eop beat: nbytes = 64 - i_empty_in. Quarter k is valid iff nbytes > 16*(3-k).
//   - eop beat: the eop bit is set only on the lowest valid quarter. Invalid quarters are all-zero. FSM -> HDR.
//   - i_sop_in in BODY is ignored; the beat is treated as body.
// - Latency and throughput:
//   - The sop beat presented at cycle T, with the output register free, gives the header at T+1 and its data flit at T+2.
//   - Steady state is 1 flit/cycle; each packet costs 1 extra cycle for the header.
// - Boundaries:
//   - i_empty_in=0 gives 4 valid quarters with eop at quarter 0 (bit Q-3).
//   - i_empty_in=63 gives only quarter 3 valid, with eop at bit NW-3.
//   - Back-to-back packets: the eop beat and the next header are in consecutive cycles, with no bubble beyond the header.
//   - Reset mid-packet aborts the packet; no eop is emitted.
// STRUCTURE
// - In global_package:
//   - Flit field offsets as localparam functions of NOC_WIDTH/NUM_VC/NOC_RADIX: FLIT_VLD, FLIT_SOP, FLIT_EOP, HDR_VC_MSB, HDR_DST_MSB, HDR_TAG_MSB, HDR_MOD_MSB.
//   - Existing mod_t.
//   - Function quarter_valid(empty) -> [3:0].
// - Sub-module noc_flit_hdr_fmt (combinational: vc, dest, tag, mod -> header flit), shared with future NoC sources.
// - Everything else (2-state FSM, rr counter, output register) lives in this module.
// TESTING
// - Reset release, 1-beat pkt, empty=0, mod=3, tag=0xA5A5_0001:
//   - Header [599:597]=110, dest=12, [551:549]=3, tag at [590:559].
//   - Then a data flit with valid at 599/449/299/149 and eop only at [147].
// - 2-beat pkt, empty=40 (24 bytes): beat 1 has all quarters valid and no eop. Beat 2 has quarters 3,2 valid, eop at [447], and bits [299:0]=0.
// - o_ready_in=0 for 3 cycles mid-packet: o_data_out/o_valid_out unchanged, i_ready_out=0, no beat lost or duplicated.
// - 5 back-to-back 1-beat packets: header dests 12,13,14,15,12; 10 flits in 10 cycles with ready=1.
// - Non-sop beat while idle: consumed (i_ready_out=1), no flit, o_proto_err high exactly 1 cycle.
// - reset low during BODY of a 3-beat pkt: o_valid_out=0 asynchronously. After release, a new sop yields a header with dest=12.

Source files
------------

// File: rtl/noc_pkt_packetizer_pkg.sv
// Shared types and flit field geometry for the parser NoC flit protocol.
// Every flit is four equal quarters; each quarter carries {valid, sop, eop} in its top three bits.
package noc_pkt_packetizer_pkg;

    typedef enum logic [2:0] {
        MOD_M0 = 3'd0,
        MOD_M1 = 3'd1,
        MOD_M2 = 3'd2,
        MOD_M3 = 3'd3,
        MOD_M4 = 3'd4,
        MOD_M5 = 3'd5,
        MOD_M6 = 3'd6,
        MOD_M7 = 3'd7
    } mod_t;

    typedef enum logic {
        ST_HDR  = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    typedef struct packed {
        state_t      state;
        mod_t        pkt_mod;
        logic [31:0] pkt_tag;
    } dbg_t;

    localparam int QUARTERS   = 4;
    localparam int LANE_BITS  = 128;
    localparam int BEAT_BYTES = 64;
    localparam int TAG_W      = 32;
    localparam int MOD_W      = 3;
    localparam int HDR_PAD_W  = 7;

    function automatic int flit_vld(input int nw, input int k);
        return (nw / QUARTERS) * k + (nw / QUARTERS) - 1;
    endfunction

    function automatic int flit_sop(input int nw, input int k);
        return flit_vld(nw, k) - 1;
    endfunction

    function automatic int flit_eop(input int nw, input int k);
        return flit_vld(nw, k) - 2;
    endfunction

    function automatic int hdr_vc_msb(input int nw);
        return nw - 4;
    endfunction

    function automatic int hdr_dst_msb(input int nw, input int vcw);
        return hdr_vc_msb(nw) - vcw;
    endfunction

    // One reserved zero bit separates the destination field from the tag.
    function automatic int hdr_tag_msb(input int nw, input int vcw, input int rw);
        return hdr_dst_msb(nw, vcw) - rw - 1;
    endfunction

    function automatic int hdr_mod_msb(input int nw, input int vcw, input int rw);
        return hdr_tag_msb(nw, vcw, rw) - TAG_W - HDR_PAD_W;
    endfunction

    // Quarter 3 carries the first 16 bytes, so valid quarters fill from the top down.
    function automatic logic [3:0] quarter_valid(input logic [5:0] empty);
        logic [6:0] nbytes;
        logic [3:0] qv;
        nbytes = 7'd64 - {1'b0, empty};
        for (int k = 0; k < QUARTERS; k++) begin
            qv[k] = (nbytes > 7'(16 * (3 - k)));
        end
        return qv;
    endfunction

    function automatic logic [3:0] lowest_valid(input logic [3:0] qv);
        return qv & ~(qv << 1);
    endfunction

endpackage

// File: rtl/noc_flit_hdr_fmt.sv
// Combinational header flit formatter: {vld,sop,eop}=110, VC, destination router, tag, target module.
// Only quarter 3 is marked valid; every other bit is zero.
module noc_flit_hdr_fmt
    import noc_pkt_packetizer_pkg::*;
#(
    parameter int NOC_WIDTH = 600,
    parameter int VCW       = 1,
    parameter int RW        = 4
) (
    input  logic [VCW-1:0]       vc,
    input  logic [RW-1:0]        dest,
    input  logic [TAG_W-1:0]     tag,
    input  mod_t                 mod,
    output logic [NOC_WIDTH-1:0] flit
);

    localparam int VLD_TOP = flit_vld(NOC_WIDTH, 3);
    localparam int SOP_TOP = flit_sop(NOC_WIDTH, 3);
    localparam int VC_MSB  = hdr_vc_msb(NOC_WIDTH);
    localparam int DST_MSB = hdr_dst_msb(NOC_WIDTH, VCW);
    localparam int TAG_MSB = hdr_tag_msb(NOC_WIDTH, VCW, RW);
    localparam int MOD_MSB = hdr_mod_msb(NOC_WIDTH, VCW, RW);

    always_comb begin
        flit                   = '0;
        flit[VLD_TOP]          = 1'b1;
        flit[SOP_TOP]          = 1'b1;
        flit[VC_MSB -: VCW]    = vc;
        flit[DST_MSB -: RW]    = dest;
        flit[TAG_MSB -: TAG_W] = tag;
        flit[MOD_MSB -: MOD_W] = mod;
    end

endmodule

// File: rtl/noc_pkt_packetizer.sv
// Transmit-side packetizer: turns an Avalon-ST packet stream into NoC flits, prefixing each packet
// with a header flit whose destination rotates round-robin over DEST.
module noc_pkt_packetizer
    import noc_pkt_packetizer_pkg::*;
#(
    parameter int DATA_WIDTH      = 512,
    parameter int NOC_WIDTH       = 600,
    parameter int NUM_VC          = 2,
    parameter int NOC_RADIX       = 16,
    parameter int VC_ID           = 0,
    parameter int NUM_SRC         = 4,
    parameter int DEST [NUM_SRC]  = '{12, 13, 14, 15}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic                  i_valid_in,
    input  logic                  i_sop_in,
    input  logic                  i_eop_in,
    input  logic [5:0]            i_empty_in,
    input  logic [2:0]            i_dest_mod_in,
    input  logic [31:0]           i_tag_in,
    output logic                  i_ready_out,
    output logic [NOC_WIDTH-1:0]  o_data_out,
    output logic                  o_valid_out,
    input  logic                  o_ready_in,
    output logic                  o_proto_err,
    output dbg_t                  dbg
);

    localparam int VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int RW  = (NOC_RADIX > 1) ? $clog2(NOC_RADIX) : 1;
    localparam int RRW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int Q   = NOC_WIDTH / QUARTERS;

    // Handshake: a beat moves when i_valid_in && i_ready_out; a flit moves when
    // o_valid_out && o_ready_in. Valid never waits on ready on either side.

    state_t               state;
    logic [RRW-1:0]       rr_idx;
    mod_t                 pkt_mod;
    logic [31:0]          pkt_tag;

    logic                 adv;
    logic                 hdr_go;
    logic                 beat_acc;
    logic [RW-1:0]        dest_sel;
    logic [3:0]           qv;
    logic [3:0]           eq;
    logic [NOC_WIDTH-1:0] hdr_flit;
    logic [NOC_WIDTH-1:0] data_flit;

    assign adv      = !o_valid_out || o_ready_in;
    assign hdr_go   = (state == ST_HDR) && i_valid_in && i_sop_in && adv;
    assign beat_acc = (state == ST_BODY) && i_valid_in && adv;
    assign dest_sel = RW'(DEST[rr_idx]);

    // The sop beat is held off in HDR so it can be re-presented as the first body beat.
    always_comb begin
        if (!reset) begin
            i_ready_out = 1'b0;
        end else if (state == ST_HDR) begin
            i_ready_out = !(i_valid_in && i_sop_in);
        end else begin
            i_ready_out = adv;
        end
    end

    noc_flit_hdr_fmt #(
        .NOC_WIDTH (NOC_WIDTH),
        .VCW       (VCW),
        .RW        (RW)
    ) u_hdr_fmt (
        .vc   (VCW'(VC_ID)),
        .dest (dest_sel),
        .tag  (i_tag_in),
        .mod  (mod_t'(i_dest_mod_in)),
        .flit (hdr_flit)
    );

    always_comb begin
        qv        = i_eop_in ? quarter_valid(i_empty_in) : 4'b1111;
        eq        = i_eop_in ? lowest_valid(qv) : 4'b0000;
        data_flit = '0;
        for (int k = 0; k < QUARTERS; k++) begin
            if (qv[k]) begin
                data_flit[Q*k +: LANE_BITS]        = i_data_in[LANE_BITS*k +: LANE_BITS];
                data_flit[flit_vld(NOC_WIDTH, k)]  = 1'b1;
                data_flit[flit_eop(NOC_WIDTH, k)]  = eq[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_HDR;
            rr_idx      <= '0;
            pkt_mod     <= MOD_M0;
            pkt_tag     <= '0;
            o_data_out  <= '0;
            o_valid_out <= 1'b0;
            o_proto_err <= 1'b0;
        end else begin
            o_proto_err <= (state == ST_HDR) && i_valid_in && !i_sop_in;
            case (state)
                ST_HDR: begin
                    if (hdr_go) begin
                        o_data_out  <= hdr_flit;
                        o_valid_out <= 1'b1;
                        pkt_mod     <= mod_t'(i_dest_mod_in);
                        pkt_tag     <= i_tag_in;
                        rr_idx      <= (rr_idx == RRW'(NUM_SRC - 1)) ? '0 : rr_idx + 1'b1;
                        state       <= ST_BODY;
                    end else if (adv) begin
                        o_valid_out <= 1'b0;
                    end
                end
                ST_BODY: begin
                    if (beat_acc) begin
                        o_data_out  <= data_flit;
                        o_valid_out <= 1'b1;
                        if (i_eop_in) begin
                            state <= ST_HDR;
                        end
                    end else if (adv) begin
                        o_valid_out <= 1'b0;
                    end
                end
                default: state <= ST_HDR;
            endcase
        end
    end

    always_comb begin
        dbg.state   = state;
        dbg.pkt_mod = pkt_mod;
        dbg.pkt_tag = pkt_tag;
    end

endmodule

// File: tb/tb_noc_pkt_packetizer.sv
// Directed bench for noc_pkt_packetizer: header/data flit layout, partial eop beats, stalls,
// back-to-back packets, protocol-error pulse and asynchronous reset mid-packet.
module tb_noc_pkt_packetizer;
    import noc_pkt_packetizer_pkg::*;

    localparam int NW = 600;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [511:0]  i_data_in = '0;
    logic          i_valid_in = 1'b0;
    logic          i_sop_in = 1'b0;
    logic          i_eop_in = 1'b0;
    logic [5:0]    i_empty_in = '0;
    logic [2:0]    i_dest_mod_in = '0;
    logic [31:0]   i_tag_in = '0;
    logic          i_ready_out;
    logic [NW-1:0] o_data_out;
    logic          o_valid_out;
    logic          o_ready_in = 1'b1;
    logic          o_proto_err;
    dbg_t          dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    noc_pkt_packetizer dut (
        .clk           (clk),
        .reset         (reset),
        .i_data_in     (i_data_in),
        .i_valid_in    (i_valid_in),
        .i_sop_in      (i_sop_in),
        .i_eop_in      (i_eop_in),
        .i_empty_in    (i_empty_in),
        .i_dest_mod_in (i_dest_mod_in),
        .i_tag_in      (i_tag_in),
        .i_ready_out   (i_ready_out),
        .o_data_out    (o_data_out),
        .o_valid_out   (o_valid_out),
        .o_ready_in    (o_ready_in),
        .o_proto_err   (o_proto_err),
        .dbg           (dbg)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkf(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic e, input logic [5:0] emp,
                         input logic [2:0] mod, input logic [31:0] tag, input logic [511:0] d);
        i_valid_in    = v;
        i_sop_in      = s;
        i_eop_in      = e;
        i_empty_in    = emp;
        i_dest_mod_in = mod;
        i_tag_in      = tag;
        i_data_in     = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 6'd0, 3'd0, 32'd0, '0);
    endtask

    function automatic logic [NW-1:0] exp_hdr(input logic [3:0] dst, input logic [31:0] tag,
                                              input logic [2:0] mod);
        logic [NW-1:0] f;
        f          = '0;
        f[599:597] = 3'b110;
        f[596]     = 1'b0;
        f[595:592] = dst;
        f[590:559] = tag;
        f[551:549] = mod;
        return f;
    endfunction

    function automatic logic [NW-1:0] exp_data(input logic [511:0] d, input logic [3:0] qv,
                                               input logic [3:0] eq);
        logic [NW-1:0] f;
        f = '0;
        for (int k = 0; k < 4; k++) begin
            if (qv[k]) begin
                f[150*k +: 128] = d[128*k +: 128];
                f[150*k + 149]  = 1'b1;
                f[150*k + 147]  = eq[k];
            end
        end
        return f;
    endfunction

    function automatic logic [511:0] beat(input logic [7:0] id);
        logic [511:0] b;
        for (int k = 0; k < 4; k++) begin
            b[128*k +: 128] = {4{id, 8'(k), 16'hC0DE}};
        end
        return b;
    endfunction

    initial begin
        logic [3:0] b2b_dst [5];
        int flits;
        b2b_dst = '{4'd12, 4'd13, 4'd14, 4'd15, 4'd12};

        // Reset state
        idle();
        #12;
        check1("rst_valid", o_valid_out, 1'b0);
        checkf("rst_data", o_data_out, '0);
        check1("rst_proto_err", o_proto_err, 1'b0);
        check1("rst_ready", i_ready_out, 1'b0);
        reset = 1'b1;
        step();

        // 1-beat packet, empty=0, mod=3
        drive(1'b1, 1'b1, 1'b1, 6'd0, 3'd3, 32'hA5A5_0001, beat(8'h11));
        #1;
        check1("p1_sop_ready", i_ready_out, 1'b0);
        step();
        check1("p1_hdr_valid", o_valid_out, 1'b1);
        checkf("p1_hdr", o_data_out, exp_hdr(4'd12, 32'hA5A5_0001, 3'd3));
        #1;
        check1("p1_body_ready", i_ready_out, 1'b1);
        step();
        idle();
        check1("p1_data_valid", o_valid_out, 1'b1);
        checkf("p1_data", o_data_out, exp_data(beat(8'h11), 4'b1111, 4'b0001));
        check1("p1_eop_q0", o_data_out[147], 1'b1);
        step();
        check1("p1_drain", o_valid_out, 1'b0);

        // 2-beat packet, eop beat carries 24 bytes
        drive(1'b1, 1'b1, 1'b0, 6'd0, 3'd5, 32'h1234_5678, beat(8'h21));
        step();
        checkf("p2_hdr", o_data_out, exp_hdr(4'd13, 32'h1234_5678, 3'd5));
        step();
        drive(1'b1, 1'b0, 1'b1, 6'd40, 3'd0, 32'd0, beat(8'h22));
        checkf("p2_beat1", o_data_out, exp_data(beat(8'h21), 4'b1111, 4'b0000));
        step();
        idle();
        checkf("p2_beat2", o_data_out, exp_data(beat(8'h22), 4'b1100, 4'b0100));
        checkf("p2_low_zero", NW'(o_data_out[299:0]), '0);
        step();
        check1("p2_drain", o_valid_out, 1'b0);

        // 3-beat packet with a 3-cycle downstream stall
        drive(1'b1, 1'b1, 1'b0, 6'd0, 3'd1, 32'h0000_0333, beat(8'h31));
        step();
        checkf("p3_hdr", o_data_out, exp_hdr(4'd14, 32'h0000_0333, 3'd1));
        step();
        o_ready_in = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 6'd0, 3'd0, 32'd0, beat(8'h32));
        checkf("p3_beat1", o_data_out, exp_data(beat(8'h31), 4'b1111, 4'b0000));
        for (int i = 0; i < 3; i++) begin
            #1;
            check1("p3_stall_ready", i_ready_out, 1'b0);
            step();
            check1("p3_stall_valid", o_valid_out, 1'b1);
            checkf("p3_stall_hold", o_data_out, exp_data(beat(8'h31), 4'b1111, 4'b0000));
        end
        o_ready_in = 1'b1;
        #1;
        check1("p3_release_ready", i_ready_out, 1'b1);
        step();
        drive(1'b1, 1'b0, 1'b1, 6'd0, 3'd0, 32'd0, beat(8'h33));
        checkf("p3_beat2", o_data_out, exp_data(beat(8'h32), 4'b1111, 4'b0000));
        step();
        idle();
        checkf("p3_beat3", o_data_out, exp_data(beat(8'h33), 4'b1111, 4'b0001));
        step();
        check1("p3_drain", o_valid_out, 1'b0);

        // Reset during the body of a 3-beat packet
        drive(1'b1, 1'b1, 1'b0, 6'd0, 3'd2, 32'h0000_0444, beat(8'h41));
        step();
        checkf("p4_hdr", o_data_out, exp_hdr(4'd15, 32'h0000_0444, 3'd2));
        step();
        drive(1'b1, 1'b0, 1'b0, 6'd0, 3'd0, 32'd0, beat(8'h42));
        checkf("p4_beat1", o_data_out, exp_data(beat(8'h41), 4'b1111, 4'b0000));
        #3;
        reset = 1'b0;
        #1;
        check1("p4_async_valid", o_valid_out, 1'b0);
        checkf("p4_async_data", o_data_out, '0);
        check1("p4_async_ready", i_ready_out, 1'b0);
        idle();
        step();
        step();
        reset = 1'b1;
        step();
        check1("p4_post_rst_valid", o_valid_out, 1'b0);

        // Five back-to-back 1-beat packets; the first header follows reset, so dest restarts at 12
        flits = 0;
        for (int p = 0; p < 5; p++) begin
            drive(1'b1, 1'b1, 1'b1, 6'd0, 3'(p), 32'hB0B0_0000 + 32'(p), beat(8'h50 + 8'(p)));
            step();
            if (o_valid_out) flits++;
            checkf("b2b_hdr", o_data_out, exp_hdr(b2b_dst[p], 32'hB0B0_0000 + 32'(p), 3'(p)));
            step();
            if (o_valid_out) flits++;
            checkf("b2b_data", o_data_out, exp_data(beat(8'h50 + 8'(p)), 4'b1111, 4'b0001));
        end
        idle();
        checkf("b2b_flit_count", NW'(flits), NW'(10));
        step();
        check1("b2b_drain", o_valid_out, 1'b0);

        // Non-sop beat while idle is dropped and flagged
        drive(1'b1, 1'b0, 1'b0, 6'd0, 3'd0, 32'd0, beat(8'h61));
        #1;
        check1("perr_ready", i_ready_out, 1'b1);
        step();
        idle();
        check1("perr_pulse", o_proto_err, 1'b1);
        check1("perr_no_flit", o_valid_out, 1'b0);
        step();
        check1("perr_clear", o_proto_err, 1'b0);
        check1("perr_no_flit2", o_valid_out, 1'b0);

        // Single-byte eop beat: only quarter 3 valid, eop at NW-3
        drive(1'b1, 1'b1, 1'b1, 6'd63, 3'd7, 32'hDEAD_BEEF, beat(8'h71));
        step();
        checkf("p5_hdr", o_data_out, exp_hdr(4'd13, 32'hDEAD_BEEF, 3'd7));
        step();
        idle();
        checkf("p5_data", o_data_out, exp_data(beat(8'h71), 4'b1000, 4'b1000));
        check1("p5_eop_top", o_data_out[597], 1'b1);
        step();
        check1("p5_drain", o_valid_out, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
